// File: rtl/bus_cycle_controller.sv
// 68000 peripheral bus cycle sequencer: per-region wait states, external-ready
// handshake, DTACK#/BERR# generation and a watchdog that logs faulting cycles.
module bus_cycle_controller #(
    parameter logic [31:0] WAIT_TABLE = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       as_n,
    input  logic       uds_n,
    input  logic       lds_n,
    input  logic       rw_n,
    input  logic [2:0] region,
    input  logic       region_valid,
    input  logic       ext_ready,
    input  logic       fault_clear,
    output logic       dtack_n,
    output logic       berr_n,
    output logic       busy,
    output logic       fault,
    output logic [2:0] fault_region,
    output logic       fault_rw_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXT,
        S_ACK,
        S_BERR
    } state_t;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, next_state;
    logic [3:0] wcnt, next_wcnt;
    logic [7:0] tcnt, next_tcnt;
    logic [2:0] region_q;
    logic       valid_q;
    logic       rw_q;
    logic       armed;
    logic       start;
    logic       berr_entry;
    logic [3:0] wait_sel;

    // armed stays set after reset until as_n has been seen high, so a strobe
    // left asserted across reset does not launch a bogus cycle.
    assign start      = !as_n && (!uds_n || !lds_n) && !armed;
    assign wait_sel   = WAIT_TABLE[{region, 2'b00} +: 4];
    assign berr_entry = (next_state == S_BERR) && (state != S_BERR);

    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        next_tcnt  = tcnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_tcnt = 8'd0;
                    if (region_valid && wait_sel == 4'hF) begin
                        next_state = S_EXT;
                    end else begin
                        next_state = S_WAIT;
                        next_wcnt  = wait_sel;
                    end
                end
            end
            S_WAIT: begin
                next_tcnt = tcnt + 8'd1;
                if (as_n) begin
                    next_state = S_IDLE;
                end else if (!valid_q) begin
                    next_state = S_BERR;
                end else if (wcnt == 4'd0) begin
                    next_state = S_ACK;
                end else begin
                    next_wcnt = wcnt - 4'd1;
                end
            end
            S_EXT: begin
                next_tcnt = tcnt + 8'd1;
                if (as_n) begin
                    next_state = S_IDLE;
                end else if (ext_ready) begin
                    next_state = S_ACK;
                end else if (tcnt == TCNT_LAST) begin
                    next_state = S_BERR;
                end
            end
            S_ACK, S_BERR: begin
                if (as_n) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Strobe outputs are registered from the next state so they change on the
    // same edge that enters or leaves ACK/BERR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            wcnt         <= 4'd0;
            tcnt         <= 8'd0;
            region_q     <= 3'd0;
            valid_q      <= 1'b0;
            rw_q         <= 1'b1;
            armed        <= 1'b1;
            dtack_n      <= 1'b1;
            berr_n       <= 1'b1;
            busy         <= 1'b0;
            fault        <= 1'b0;
            fault_region <= 3'd0;
            fault_rw_n   <= 1'b1;
        end else begin
            state   <= next_state;
            wcnt    <= next_wcnt;
            tcnt    <= next_tcnt;
            dtack_n <= (next_state != S_ACK);
            berr_n  <= (next_state != S_BERR);
            busy    <= (next_state != S_IDLE);
            if (as_n) begin
                armed <= 1'b0;
            end
            if (state == S_IDLE && start) begin
                region_q <= region;
                valid_q  <= region_valid;
                rw_q     <= rw_n;
            end
            if (berr_entry) begin
                fault        <= 1'b1;
                fault_region <= region_q;
                fault_rw_n   <= rw_q;
            end else if (fault_clear) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller: directed scenarios plus random
// cycles compared against a latency/fault model derived from the wait table.
module tb_bus_cycle_controller;

    localparam logic [31:0] TABLE = 32'hFA63_F0E1;
    localparam int          TMO   = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       as_n = 1'b1;
    logic       uds_n = 1'b1;
    logic       lds_n = 1'b1;
    logic       rw_n = 1'b1;
    logic [2:0] region = 3'd0;
    logic       region_valid = 1'b0;
    logic       ext_ready = 1'b0;
    logic       fault_clear = 1'b0;
    logic       dtack_n;
    logic       berr_n;
    logic       busy;
    logic       fault;
    logic [2:0] fault_region;
    logic       fault_rw_n;

    int total = 0;
    int bad = 0;

    // Wait counts per region, written independently of the packed TABLE value.
    int wt[8] = '{1, 14, 0, 15, 3, 6, 10, 15};

    logic       mfault = 1'b0;
    logic [2:0] mreg = 3'd0;
    logic       mrw = 1'b1;

    bus_cycle_controller #(.WAIT_TABLE(TABLE), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
        .rw_n(rw_n), .region(region), .region_valid(region_valid),
        .ext_ready(ext_ready), .fault_clear(fault_clear), .dtack_n(dtack_n),
        .berr_n(berr_n), .busy(busy), .fault(fault), .fault_region(fault_region),
        .fault_rw_n(fault_rw_n)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One complete bus cycle: start, hold for the expected latency plus extra
    // clocks, then release. ext_at/clr_at < 0 means never.
    task automatic run_cycle(input int r, input logic v, input logic rw, input int ds,
                             input int ext_at, input int hold, input int clr_at,
                             input string name);
        int w;
        int exp_edge;
        logic exp_berr;
        logic exp_d;
        logic exp_b;
        w = wt[r];
        if (!v) begin
            exp_berr = 1'b1;
            exp_edge = 1;
        end else if (w == 15) begin
            if (ext_at >= 1 && ext_at <= TMO) begin
                exp_berr = 1'b0;
                exp_edge = ext_at;
            end else begin
                exp_berr = 1'b1;
                exp_edge = TMO;
            end
        end else begin
            exp_berr = 1'b0;
            exp_edge = 1 + w;
        end
        region       = r[2:0];
        region_valid = v;
        rw_n         = rw;
        as_n         = 1'b0;
        uds_n        = (ds == 1);
        lds_n        = (ds == 0);
        for (int k = 0; k <= exp_edge + hold; k++) begin
            if (k == ext_at) ext_ready = 1'b1;
            if (k == clr_at) fault_clear = 1'b1;
            tick();
            fault_clear = 1'b0;
            if (exp_berr && k == exp_edge) begin
                mfault = 1'b1;
                mreg   = r[2:0];
                mrw    = rw;
            end else if (k == clr_at) begin
                mfault = 1'b0;
            end
            exp_d = !(!exp_berr && k >= exp_edge);
            exp_b = !(exp_berr && k >= exp_edge);
            total++;
            if ({dtack_n, berr_n, busy} !== {exp_d, exp_b, 1'b1}) begin
                bad++;
                $display("[TB] FAIL %s strobes S+%0d: dtack_n/berr_n/busy=%b required %b",
                         name, k, {dtack_n, berr_n, busy}, {exp_d, exp_b, 1'b1});
            end
            total++;
            if ({fault, fault_region, fault_rw_n} !== {mfault, mreg, mrw}) begin
                bad++;
                $display("[TB] FAIL %s fault S+%0d: fault/region/rw_n=%b required %b",
                         name, k, {fault, fault_region, fault_rw_n}, {mfault, mreg, mrw});
            end
        end
        as_n         = 1'b1;
        uds_n        = 1'b1;
        lds_n        = 1'b1;
        ext_ready    = 1'b0;
        region       = 3'($urandom);
        region_valid = 1'($urandom);
        tick();
        total++;
        if ({dtack_n, berr_n, busy, fault} !== {3'b110, mfault}) begin
            bad++;
            $display("[TB] FAIL %s release: dtack_n/berr_n/busy/fault=%b required %b",
                     name, {dtack_n, berr_n, busy, fault}, {3'b110, mfault});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({dtack_n, berr_n, busy, fault, fault_region, fault_rw_n} !== 8'b1100_0001) begin
            bad++;
            $display("[TB] FAIL reset_values: got %b required %b",
                     {dtack_n, berr_n, busy, fault, fault_region, fault_rw_n}, 8'b1100_0001);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_no_strobe;
        as_n = 1'b0;
        region = 3'd2;
        region_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({dtack_n, berr_n, busy} !== 3'b110) begin
                bad++;
                $display("[TB] FAIL no_strobe: dtack_n/berr_n/busy=%b required 110",
                         {dtack_n, berr_n, busy});
            end
        end
        as_n = 1'b1;
        tick();
    endtask

    task automatic test_wait_states;
        run_cycle(2, 1'b1, 1'b1, 1, -1, 2, -1, "zero_wait_read");
        run_cycle(5, 1'b1, 1'b0, 2, -1, 1, -1, "wait6_write");
        run_cycle(1, 1'b1, 1'b1, 0, -1, 0, -1, "wait14_max");
    endtask

    task automatic test_ext_ready;
        run_cycle(3, 1'b1, 1'b1, 2, 20, 1, -1, "ext_ready20");
        run_cycle(3, 1'b1, 1'b1, 0, 1, 0, -1, "ext_earliest");
        run_cycle(7, 1'b1, 1'b0, 2, TMO, 1, -1, "ext_at_timeout");
        run_cycle(3, 1'b1, 1'b1, 2, -1, 2, -1, "timeout");
    endtask

    task automatic test_undecoded;
        run_cycle(4, 1'b0, 1'b0, 2, -1, 1, -1, "undecoded");
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        mfault = 1'b0;
        total++;
        if ({fault, fault_region, fault_rw_n} !== {1'b0, 3'd4, 1'b0}) begin
            bad++;
            $display("[TB] FAIL fault_clear: fault/region/rw_n=%b required %b",
                     {fault, fault_region, fault_rw_n}, {1'b0, 3'd4, 1'b0});
        end
        run_cycle(6, 1'b0, 1'b1, 1, -1, 2, 1, "clear_vs_set");
        run_cycle(0, 1'b0, 1'b0, 2, -1, 3, 3, "clear_in_berr");
    endtask

    task automatic test_abort;
        region = 3'd6;
        region_valid = 1'b1;
        as_n = 1'b0;
        uds_n = 1'b0;
        lds_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({dtack_n, berr_n, busy} !== 3'b111) begin
                bad++;
                $display("[TB] FAIL abort_wait S+%0d: dtack_n/berr_n/busy=%b required 111",
                         k, {dtack_n, berr_n, busy});
            end
        end
        as_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({dtack_n, berr_n, busy, fault} !== {3'b110, mfault}) begin
                bad++;
                $display("[TB] FAIL abort_idle: dtack_n/berr_n/busy/fault=%b required %b",
                         {dtack_n, berr_n, busy, fault}, {3'b110, mfault});
            end
        end
    endtask

    task automatic test_reset_midcycle;
        run_cycle(5, 1'b0, 1'b0, 2, -1, 0, -1, "pre_reset_fault");
        region = 3'd1;
        region_valid = 1'b1;
        as_n = 1'b0;
        uds_n = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mfault = 1'b0;
        mreg = 3'd0;
        mrw = 1'b1;
        total++;
        if ({dtack_n, berr_n, busy, fault, fault_region, fault_rw_n} !== 8'b1100_0001) begin
            bad++;
            $display("[TB] FAIL reset_midcycle: got %b required %b",
                     {dtack_n, berr_n, busy, fault, fault_region, fault_rw_n}, 8'b1100_0001);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({dtack_n, berr_n, busy} !== 3'b110) begin
                bad++;
                $display("[TB] FAIL no_restart %0d: dtack_n/berr_n/busy=%b required 110",
                         k, {dtack_n, berr_n, busy});
            end
        end
        as_n = 1'b1;
        uds_n = 1'b1;
        tick();
        run_cycle(2, 1'b1, 1'b1, 2, -1, 1, -1, "after_rearm");
    endtask

    task automatic test_back_to_back;
        run_cycle(2, 1'b1, 1'b1, 1, -1, 0, -1, "b2b_first");
        run_cycle(2, 1'b1, 1'b0, 0, -1, 0, -1, "b2b_second");
    endtask

    task automatic test_random;
        int r;
        int ext_at;
        int clr_at;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 7);
            ext_at = (wt[r] == 15) ? $urandom_range(1, 40) : -1;
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_cycle(r, 1'($urandom_range(0, 5) != 0), 1'($urandom), $urandom_range(0, 2),
                      ext_at, $urandom_range(0, 3), clr_at, "random");
        end
    endtask

    initial begin
        test_reset();
        test_no_strobe();
        test_wait_states();
        test_ext_ready();
        test_undecoded();
        test_abort();
        test_reset_midcycle();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
